rca16_adder: RTL and testbench

- Unsigned 16-bit ripple-carry adder with carry-in and carry-out.
- The combinational adder is a chain of 1-bit full adders; its result is captured in an output register.
- The block serves as the baseline arithmetic datapath element, and wider or faster adders are compared against it.
- One clock domain, with an asynchronous active-low reset.

---
 rtl/rca16_adder_pkg.sv | 12 +
 rtl/full_adder.sv | 22 ++
 rtl/rca16_adder.sv | 69 ++++++
 tb/tb_rca16_adder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rca16_adder_pkg.sv
// ---------------------------------------------------------------------------
// rca16_adder_pkg
// Shared constants for the ripple-carry adder slice.
//   WIDTH_DEFAULT : default operand / sum width in bits
//   RESULT_WIDTH  : width of the exact result {cout, sum}
// ---------------------------------------------------------------------------
package rca16_adder_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int RESULT_WIDTH  = WIDTH_DEFAULT + 1;

endpackage : rca16_adder_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell. It is the building block of the ripple chain.
// Ports:
//   a, b : operand bits
//   ci   : carry in from the next lower bit
//   s    : sum bit
//   co   : carry out to the next higher bit
// ---------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum is the three-way parity. Carry is the majority of the three inputs.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/rca16_adder.sv
// ---------------------------------------------------------------------------
// rca16_adder
// Unsigned ripple-carry adder with carry-in and carry-out, followed by a
// single output register stage. It is the baseline datapath element that
// wider or faster adders are compared against.
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : qualifies A, B and cin for capture this cycle
//   A, B      : unsigned operands, WIDTH bits
//   cin       : carry into bit 0
//   sum       : registered sum, WIDTH bits
//   cout      : registered carry out of the top bit
//   out_valid : high for one cycle when sum/cout hold a new result
// ---------------------------------------------------------------------------
module rca16_adder
  import rca16_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  // carry[i] is the carry into bit i. carry[WIDTH] is the final carry out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;

  assign carry[0] = cin;

  // The carry ripples strictly from bit 0 upwards through WIDTH cells. There
  // is no lookahead, so the critical path is the full chain and sets the
  // maximum clock frequency.
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  // Output register stage. A valid input is captured on the next edge and
  // out_valid marks it for exactly one cycle. Without in_valid, the previous
  // result stays visible but is no longer flagged. Reset clears everything
  // at once, so a result that was pending when reset arrived is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= carry[WIDTH];
      end
    end
  end

endmodule : rca16_adder

// File: tb/tb_rca16_adder.sv
// ---------------------------------------------------------------------------
// tb_rca16_adder
// Self-checking bench for rca16_adder. Each driven valid input pushes its
// expected {cout, sum} to a scoreboard queue. The entry is popped and
// compared when the registered output appears one cycle later.
// ---------------------------------------------------------------------------
module tb_rca16_adder;
  import rca16_adder_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  typedef struct packed {
    logic         c;
    logic [W-1:0] s;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         inValid;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic         carryIn;
  logic [W-1:0] sum;
  logic         cout;
  logic         outValid;

  exp_t         expQ[$];
  logic [W-1:0] heldSum;
  logic         heldCout;
  int           checkCount;
  int           passCount;

  rca16_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .A         (opA),
    .B         (opB),
    .cin       (carryIn),
    .sum       (sum),
    .cout      (cout),
    .out_valid (outValid)
  );

  // 10 time-unit clock. The first rising edge is at t=5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one cycle of inputs (called at a falling edge). Valid inputs push
  // their reference result, computed exactly over RESULT_WIDTH bits.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic v);
    logic [RESULT_WIDTH-1:0] ref17;
    exp_t e;
    opA     = a;
    opB     = b;
    carryIn = c;
    inValid = v;
    if (v) begin
      ref17 = {1'b0, a} + {1'b0, b} + {{(RESULT_WIDTH-1){1'b0}}, c};
      e.c = ref17[RESULT_WIDTH-1];
      e.s = ref17[W-1:0];
      expQ.push_back(e);
    end
  endtask

  // Check the outputs just after the capturing edge. A new result is popped
  // from the scoreboard. Otherwise the outputs must hold with out_valid low.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      compare({tag, ".valid"}, 32'(outValid), 32'd1);
      compare({tag, ".sum"},   32'(sum),      32'(e.s));
      compare({tag, ".cout"},  32'(cout),     32'(e.c));
      heldSum  = e.s;
      heldCout = e.c;
    end else begin
      compare({tag, ".valid"}, 32'(outValid), 32'd0);
      compare({tag, ".sum"},   32'(sum),      32'(heldSum));
      compare({tag, ".cout"},  32'(cout),     32'(heldCout));
    end
  endtask

  // One full cycle: drive at the falling edge, check 1 after the rising edge,
  // then return to the next falling edge.
  task automatic step(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic v);
    applyStimulus(a, b, c, v);
    @(posedge clk);
    #1;
    checkOutput(tag);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle while a valid all-ones operation is presented.
  // The outputs must clear at once and stay clear across a clock edge.
  // Any pending expectation is discarded.
  task automatic doReset(input string tag);
    opA     = '1;
    opB     = '1;
    carryIn = 1'b1;
    inValid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compare({tag, ".async_valid"}, 32'(outValid), 32'd0);
    compare({tag, ".async_sum"},   32'(sum),      32'd0);
    compare({tag, ".async_cout"},  32'(cout),     32'd0);
    @(posedge clk);
    #1;
    compare({tag, ".held_valid"}, 32'(outValid), 32'd0);
    compare({tag, ".held_sum"},   32'(sum),      32'd0);
    compare({tag, ".held_cout"},  32'(cout),     32'd0);
    expQ.delete();
    heldSum  = '0;
    heldCout = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    inValid = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    heldSum    = '0;
    heldCout   = 1'b0;
    rst_n      = 1'b1;
    inValid    = 1'b1;
    opA        = '1;
    opB        = '1;
    carryIn    = 1'b1;

    // Power-on reset, applied asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    compare("por.valid", 32'(outValid), 32'd0);
    compare("por.sum",   32'(sum),      32'd0);
    compare("por.cout",  32'(cout),     32'd0);
    @(posedge clk);
    #1;
    compare("por_held.valid", 32'(outValid), 32'd0);
    compare("por_held.sum",   32'(sum),      32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    inValid = 1'b0;

    // The cycle right after release carries no stale result.
    step("post_release", 16'd1, 16'd2, 1'b0, 1'b0);

    // Overflow case.
    step("overflow", 16'd65000, 16'd65340, 1'b0, 1'b1);

    // Mixed cases, back-to-back.
    step("mix0", 16'd58135, 16'd3592,  1'b0, 1'b1);
    step("mix1", 16'd1005,  16'd69,    1'b1, 1'b1);
    step("mix2", 16'd15124, 16'd5383,  1'b1, 1'b1);
    step("mix3", 16'd50,    16'd10024, 1'b0, 1'b1);

    // Full-length carry propagation and the all-ones boundary.
    step("ripple",   16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step("all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    step("zeros",    16'h0000, 16'h0000, 1'b0, 1'b1);
    step("pre_hold", 16'd12345, 16'd54321, 1'b1, 1'b1);

    // Hold: new operands without in_valid must not disturb the outputs.
    for (int i = 0; i < 3; i++) begin
      step("hold", 16'(16'hA5A5 + i), 16'(16'h5A5A - i), 1'(i), 1'b0);
    end

    // Mid-operation reset with a result already in the register.
    step("pre_reset", 16'd40000, 16'd40000, 1'b1, 1'b1);
    doReset("rst_mid");
    step("after_rst", 16'd7, 16'd9, 1'b0, 1'b0);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 10000; i++) begin
      if (i == 2500 || i == 5000 || i == 7500 || $urandom_range(0, 999) == 0) begin
        doReset("rnd_rst");
      end
      step("rnd", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] done at t=%0t", $time);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_rca16_adder
